// File: rtl/coin_acceptor.sv
// Coin-sensor front end: 2-flop sync, debounce, denomination decode, and the x/value strobe.
// Define COIN_COUNT_EN to add the saturating accepted-coin counter output coin_cnt.
module coin_acceptor #(
  parameter int unsigned DEB_CYCLES  = 4,
  parameter int unsigned HOLD_CYCLES = 3,
  parameter logic [7:0]  VAL0        = 8'd5,
  parameter logic [7:0]  VAL1        = 8'd10,
  parameter logic [7:0]  VAL2        = 8'd25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  coin_sens,
  output logic        x,
  output logic [7:0]  value,
  output logic        coin_err,
  output logic        busy
`ifdef COIN_COUNT_EN
  ,
  output logic [15:0] coin_cnt
`endif
);

  typedef enum logic [2:0] {
    StIdle,
    StDebounce,
    StSetup,
    StStrobe,
    StRelease,
    StErr
  } state_e;

  localparam logic [3:0] DebLast  = 4'(DEB_CYCLES - 1);
  localparam logic [3:0] HoldLast = 4'(HOLD_CYCLES);

  state_e     state;
  logic [2:0] s1, s2, pat;
  logic [3:0] cnt, hcnt;
  logic [7:0] pat_val;
  logic       pat_onehot;

  assign pat_onehot = $onehot(pat);

  always_comb begin
    pat_val = 8'd0;
    case (pat)
      3'b001:  pat_val = VAL0;
      3'b010:  pat_val = VAL1;
      3'b100:  pat_val = VAL2;
      default: pat_val = 8'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= 3'b000;
      s2       <= 3'b000;
      pat      <= 3'b000;
      cnt      <= 4'd0;
      hcnt     <= 4'd0;
      state    <= StIdle;
      x        <= 1'b1;
      value    <= 8'd0;
      coin_err <= 1'b0;
      busy     <= 1'b0;
`ifdef COIN_COUNT_EN
      coin_cnt <= 16'd0;
`endif
    end else begin
      s1       <= coin_sens;
      s2       <= s1;
      coin_err <= 1'b0;
      case (state)
        StIdle: begin
          if (s2 != 3'b000) begin
            state <= StDebounce;
            pat   <= s2;
            cnt   <= 4'd1;
            busy  <= 1'b1;
          end
        end
        StDebounce: begin
          if (s2 == 3'b000) begin
            state <= StIdle;
            busy  <= 1'b0;
          end else if (s2 != pat) begin
            pat <= s2;
            cnt <= 4'd1;
          end else if (cnt != DebLast) begin
            cnt <= cnt + 4'd1;
          end else if (pat_onehot) begin
            state <= StSetup;
            value <= pat_val;
`ifdef COIN_COUNT_EN
            if (coin_cnt != 16'hFFFF) coin_cnt <= coin_cnt + 16'd1;
`endif
          end else begin
            state    <= StErr;
            coin_err <= 1'b1;
            cnt      <= 4'd0;
          end
        end
        // value already stable for a full cycle before x falls
        StSetup: begin
          state <= StStrobe;
          x     <= 1'b0;
          hcnt  <= 4'd1;
        end
        StStrobe: begin
          if (hcnt == HoldLast) begin
            state <= StRelease;
            x     <= 1'b1;
            cnt   <= 4'd0;
          end else begin
            hcnt <= hcnt + 4'd1;
          end
        end
        // Sensor must read empty for DEB_CYCLES samples in a row before re-arming.
        StRelease, StErr: begin
          if (s2 != 3'b000) begin
            cnt <= 4'd0;
          end else if (cnt == DebLast) begin
            state <= StIdle;
            value <= 8'd0;
            busy  <= 1'b0;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          state <= StIdle;
          x     <= 1'b1;
          value <= 8'd0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: vector table, hand-written corner sequences and
// random sensor bursts compared against a timeline-based reference model.
module tb_coin_acceptor;

  localparam int DEB  = 4;
  localparam int HOLD = 3;
  localparam logic [7:0] V0 = 8'd5;
  localparam logic [7:0] V1 = 8'd10;
  localparam logic [7:0] V2 = 8'd25;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] coin_sens;
  logic       x;
  logic [7:0] value;
  logic       coin_err;
  logic       busy;
`ifdef COIN_COUNT_EN
  logic [15:0] coin_cnt;
`endif

  always #5 clk = ~clk;

  coin_acceptor #(
    .DEB_CYCLES (DEB),
    .HOLD_CYCLES(HOLD),
    .VAL0       (V0),
    .VAL1       (V1),
    .VAL2       (V2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .coin_sens(coin_sens),
    .x        (x),
    .value    (value),
    .coin_err (coin_err),
    .busy     (busy)
`ifdef COIN_COUNT_EN
    ,
    .coin_cnt (coin_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int falls  = 0;
  logic       prev_x   = 1'b1;
  logic [7:0] prev_val = 8'd0;

  // Reference model: a coin is described by the edge it was accepted at; everything after
  // that is arithmetic on the age of the coin plus a run of empty sensor samples.
  logic [2:0] pipe[$];
  int         edge_n, run, acc_edge, err_edge, zero_run, m_cnt;
  logic [2:0] m_pat;
  logic       e_x, e_err, e_busy;
  logic [7:0] e_val;

  function automatic logic [7:0] denom(input logic [2:0] p);
    if (p == 3'b001) return V0;
    if (p == 3'b010) return V1;
    if (p == 3'b100) return V2;
    return 8'd0;
  endfunction

  task automatic model_step(input logic r, input logic [2:0] cs);
    logic [2:0] seen;
    int age;
    if (r) begin
      pipe = '{3'b000, 3'b000};
      edge_n = 0; run = 0; acc_edge = -1; err_edge = -1; zero_run = 0; m_cnt = 0;
      m_pat = 3'b000; e_x = 1'b1; e_val = 8'd0; e_err = 1'b0; e_busy = 1'b0;
      return;
    end
    pipe.push_back(cs);
    seen = pipe.pop_front();
    edge_n++;
    e_err = 1'b0;
    if (acc_edge >= 0 || err_edge >= 0) begin
      age = edge_n - ((acc_edge >= 0) ? acc_edge : err_edge);
      if (acc_edge >= 0) e_x = !(age >= 1 && age <= HOLD);
      if (err_edge >= 0 || age >= HOLD + 2) begin
        zero_run = (seen == 3'b000) ? zero_run + 1 : 0;
        if (zero_run == DEB) begin
          acc_edge = -1; err_edge = -1; zero_run = 0;
          e_val = 8'd0; e_busy = 1'b0;
        end
      end
    end else if (run > 0) begin
      if (seen == 3'b000) begin
        run = 0; e_busy = 1'b0;
      end else if (seen != m_pat) begin
        m_pat = seen; run = 1;
      end else begin
        run++;
        if (run == DEB) begin
          run = 0; zero_run = 0;
          if ($countones(m_pat) == 1) begin
            acc_edge = edge_n; e_val = denom(m_pat);
            if (m_cnt != 65535) m_cnt++;
          end else begin
            err_edge = edge_n; e_err = 1'b1;
          end
        end
      end
    end else if (seen != 3'b000) begin
      run = 1; m_pat = seen; e_busy = 1'b1;
    end
  endtask

  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, req);
    end
  endtask

  // Drives one cycle from a negedge, steps the model at the posedge, checks 1 ns later.
  task automatic tick(input logic r, input logic [2:0] cs);
    rst = r;
    coin_sens = cs;
    @(posedge clk);
    model_step(r, cs);
    #1;
    cyc++;
    cmp("model_x", 16'(x), 16'(e_x));
    cmp("model_value", 16'(value), 16'(e_val));
    cmp("model_coin_err", 16'(coin_err), 16'(e_err));
    cmp("model_busy", 16'(busy), 16'(e_busy));
`ifdef COIN_COUNT_EN
    cmp("model_coin_cnt", coin_cnt, 16'(m_cnt));
`endif
    if (!x) begin
      cmp("x_low_value_nonzero", 16'(value != 8'd0), 16'd1);
      if (!prev_x) cmp("value_stable_while_low", 16'(value), 16'(prev_val));
    end
    if (prev_x && !x) falls++;
    prev_x = x;
    prev_val = value;
    @(negedge clk);
  endtask

  typedef struct {
    logic       r;
    logic [2:0] cs;
    int         reps;
    logic       x;
    logic [7:0] val;
    logic       err;
    logic       busy;
  } vec_t;

  localparam int NV = 20;
  vec_t vec[NV];

  initial begin
    logic [2:0] cs;
    int dur;
    logic r;

    vec = '{
      // reset and idle
      '{1'b1, 3'b000, 2,  1'b1, 8'd0,  1'b0, 1'b0},
      '{1'b0, 3'b000, 1,  1'b1, 8'd0,  1'b0, 1'b0},
      // single 10-unit coin held 20 cycles from edge k
      '{1'b0, 3'b010, 2,  1'b1, 8'd0,  1'b0, 1'b0},
      '{1'b0, 3'b010, 3,  1'b1, 8'd0,  1'b0, 1'b1},
      '{1'b0, 3'b010, 1,  1'b1, 8'd10, 1'b0, 1'b1},
      '{1'b0, 3'b010, 3,  1'b0, 8'd10, 1'b0, 1'b1},
      '{1'b0, 3'b010, 11, 1'b1, 8'd10, 1'b0, 1'b1},
      '{1'b0, 3'b000, 5,  1'b1, 8'd10, 1'b0, 1'b1},
      '{1'b0, 3'b000, 2,  1'b1, 8'd0,  1'b0, 1'b0},
      // invalid pattern held 10 cycles
      '{1'b0, 3'b011, 2,  1'b1, 8'd0,  1'b0, 1'b0},
      '{1'b0, 3'b011, 3,  1'b1, 8'd0,  1'b0, 1'b1},
      '{1'b0, 3'b011, 1,  1'b1, 8'd0,  1'b1, 1'b1},
      '{1'b0, 3'b011, 4,  1'b1, 8'd0,  1'b0, 1'b1},
      '{1'b0, 3'b000, 5,  1'b1, 8'd0,  1'b0, 1'b1},
      '{1'b0, 3'b000, 2,  1'b1, 8'd0,  1'b0, 1'b0},
      // two-cycle glitch
      '{1'b0, 3'b100, 2,  1'b1, 8'd0,  1'b0, 1'b0},
      '{1'b0, 3'b000, 2,  1'b1, 8'd0,  1'b0, 1'b1},
      '{1'b0, 3'b000, 2,  1'b1, 8'd0,  1'b0, 1'b0},
      // 25-unit coin at the start of a drain, short hold
      '{1'b0, 3'b100, 5,  1'b1, 8'd0,  1'b0, 1'b0},
      '{1'b0, 3'b100, 1,  1'b1, 8'd25, 1'b0, 1'b1}
    };
    // Row 18 covers edges k..k+4 collectively, so its busy column only matches at k..k+1;
    // split handling below keeps the table strict.
    vec[18].reps = 2;

    rst = 1'b1;
    coin_sens = 3'b000;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      if (i == 19) begin
        for (int j = 0; j < 3; j++) begin
          tick(1'b0, 3'b100);
          cmp("tbl_busy_deb", 16'(busy), 16'd1);
          cmp("tbl_x_deb", 16'(x), 16'd1);
        end
      end
      for (int n = 0; n < vec[i].reps; n++) begin
        tick(vec[i].r, vec[i].cs);
        cmp("tbl_x", 16'(x), 16'(vec[i].x));
        cmp("tbl_value", 16'(value), 16'(vec[i].val));
        cmp("tbl_coin_err", 16'(coin_err), 16'(vec[i].err));
        cmp("tbl_busy", 16'(busy), 16'(vec[i].busy));
      end
      if (i == 17) cmp("tbl_x_falls", 16'(falls), 16'd1);
    end
    // finish the 25-unit coin and let it drain
    for (int n = 0; n < 3; n++) begin
      tick(1'b0, 3'b100);
      cmp("c25_x_low", 16'(x), 16'd0);
    end
    tick(1'b0, 3'b000);
    cmp("c25_x_back", 16'(x), 16'd1);
    for (int n = 0; n < 8; n++) tick(1'b0, 3'b000);
    cmp("c25_idle_value", 16'(value), 16'd0);
    cmp("c25_idle_busy", 16'(busy), 16'd0);

    // reset on the second cycle of x low
    for (int n = 0; n < 7; n++) tick(1'b0, 3'b001);
    cmp("rst_mid_x_low1", 16'(x), 16'd0);
    tick(1'b0, 3'b001);
    cmp("rst_mid_x_low2", 16'(x), 16'd0);
    tick(1'b1, 3'b001);
    cmp("rst_mid_x", 16'(x), 16'd1);
    cmp("rst_mid_value", 16'(value), 16'd0);
    cmp("rst_mid_busy", 16'(busy), 16'd0);
    for (int n = 0; n < 3; n++) begin
      tick(1'b1, 3'b001);
      cmp("rst_hold_x", 16'(x), 16'd1);
      cmp("rst_hold_value", 16'(value), 16'd0);
    end
    for (int n = 0; n < 6; n++) tick(1'b0, 3'b000);

`ifdef COIN_COUNT_EN
    tick(1'b1, 3'b000);
    begin
      logic [2:0] seq[4];
      seq = '{3'b001, 3'b100, 3'b010, 3'b110};
      for (int c = 0; c < 4; c++) begin
        for (int n = 0; n < 20; n++) tick(1'b0, seq[c]);
        for (int n = 0; n < 10; n++) tick(1'b0, 3'b000);
      end
    end
    cmp("coin_cnt_three", coin_cnt, 16'd3);
`endif

    // random sensor bursts
    for (int b = 0; b < 350; b++) begin
      if ($urandom_range(0, 9) < 7) begin
        case ($urandom_range(0, 3))
          0: cs = 3'b000;
          1: cs = 3'b001;
          2: cs = 3'b010;
          default: cs = 3'b100;
        endcase
      end else begin
        cs = 3'($urandom_range(0, 7));
      end
      dur = $urandom_range(1, 24);
      r = ($urandom_range(0, 59) == 0);
      for (int n = 0; n < dur; n++) tick(r && (n == 0), cs);
    end
    for (int n = 0; n < 30; n++) tick(1'b0, 3'b000);
    cmp("final_idle_busy", 16'(busy), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
